// File: rtl/ram_port_arbiter_if.sv
// Purpose: one requester's transaction channel into the RAM port arbiter (request side plus read return).
// Latency: none here; pure signal bundle, timing is set by the arbiter.
// Backpressure: gnt qualifies req; a transfer happens on an edge with req & gnt, rvalid is never stalled.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    // Requester side: issues transactions, receives grant and read data.
    modport master (
        output req, wr, addr, wdata,
        input  gnt, rdata, rvalid
    );

    // Arbiter side: accepts transactions, returns grant and read data.
    modport slave (
        input  req, wr, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Purpose: round-robin arbiter/sequencer for two requesters sharing one single-port sync RAM with a bidirectional bus.
// Latency: write drives RAM the cycle after grant; read data returns with rvalid 3 cycles after grant.
// Backpressure: gnt is combinational and held low during the READ cycle; rvalid cannot be stalled.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     a_if,
    ram_port_arbiter_if.slave     b_if,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    // IDLE: nothing in flight. WRITE: arbiter drives the bus. READ: RAM samples
    // the address. RCAP: RAM drives the bus and the arbiter captures it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RCAP  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  ram_we_q,  ram_we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  owner_b_q, owner_b_d;   // 1 = current read belongs to B
    logic                  last_b_q,  last_b_d;    // 1 = B won the most recent transfer
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;

    logic                  free;
    logic                  a_gnt_c;
    logic                  b_gnt_c;
    logic                  xfer;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Round-robin grant: a lone requester wins; on conflict the one not served last wins.
    always_comb begin
        free      = (state_q != S_READ);
        a_gnt_c   = free && a_if.req && (!b_if.req || last_b_q);
        b_gnt_c   = free && b_if.req && !a_gnt_c;
        xfer      = a_gnt_c || b_gnt_c;
        sel_wr    = a_gnt_c ? a_if.wr    : b_if.wr;
        sel_addr  = a_gnt_c ? a_if.addr  : b_if.addr;
        sel_wdata = a_gnt_c ? a_if.wdata : b_if.wdata;
    end

    // Sequencer next state, RAM pin values and read-return capture.
    always_comb begin
        state_d    = state_q;
        ram_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        owner_b_d  = owner_b_q;
        last_b_d   = last_b_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;

        // READ must always be followed by RCAP so the RAM output gets captured;
        // every other state is free to accept the next transfer.
        if (state_q == S_READ) begin
            state_d = S_RCAP;
        end else if (xfer) begin
            state_d   = sel_wr ? S_WRITE : S_READ;
            ram_we_d  = sel_wr;
            addr_d    = sel_addr;
            wdata_d   = sel_wdata;
            owner_b_d = b_gnt_c;
            last_b_d  = b_gnt_c;
        end else begin
            state_d = S_IDLE;
        end

        // The RAM is driving the bus during RCAP; sample it for the read's owner.
        // A transfer accepted in this same cycle only changes owner at the edge.
        if (state_q == S_RCAP) begin
            if (owner_b_q) begin
                b_rdata_d  = ram_data;
                b_rvalid_d = 1'b1;
            end else begin
                a_rdata_d  = ram_data;
                a_rvalid_d = 1'b1;
            end
        end
    end

    // State and output registers; reset clears everything and releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ram_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_b_q  <= 1'b0;
            last_b_q   <= 1'b1;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_we_q   <= ram_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            owner_b_q  <= owner_b_d;
            last_b_q   <= last_b_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Write enable and bus drive enable share one flop, so the arbiter can only
    // drive while the RAM is in write mode and therefore not driving.
    assign ram_data = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_we   = ram_we_q;
    assign ram_addr = addr_q;
    assign busy     = (state_q != S_IDLE);

    assign a_if.gnt    = a_gnt_c;
    assign b_if.gnt    = b_gnt_c;
    assign a_if.rdata  = a_rdata_q;
    assign b_if.rdata  = b_rdata_q;
    assign a_if.rvalid = a_rvalid_q;
    assign b_if.rvalid = b_rvalid_q;

    // Grants are exclusive and never issued while the RAM is sampling a read address.
    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt_c && b_gnt_c));
    a_no_gnt_in_read: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_READ) |-> !(a_gnt_c || b_gnt_c));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(a_rvalid_q && b_rvalid_q));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: self-checking bench for ram_port_arbiter with a behavioural single-port RAM and a transaction-level model.
// Latency: model schedules write pins one cycle and read returns three cycles after each accepted transfer.
// Backpressure: stimulus holds or drops requests freely; the model predicts every grant.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          busy;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_if     (a_if),
        .b_if     (b_if),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy)
    );

    // Single-port synchronous RAM: writes on we, otherwise registers the addressed
    // word and drives it onto the bus whenever it is not being written.
    logic [DW-1:0] ram_mem [8] = '{default: 8'h00};
    logic [DW-1:0] ram_dout    = 8'h00;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        else        ram_dout          <= ram_mem[ram_addr];
    end
    assign ram_data = ram_we ? {DW{1'bz}} : ram_dout;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    typedef struct {
        int            due;
        bit            to_b;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] mdl_mem [8] = '{default: 8'h00};
    int            cyc;
    bit            last_b;      // B served last, so A wins the next conflict
    bit            blocked;     // this cycle is the address cycle of a read
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            exp_busy;
    logic [DW-1:0] exp_a_rdata;
    logic [DW-1:0] exp_b_rdata;

    task automatic mdl_reset();
        rq.delete();
        last_b      = 1'b1;
        blocked     = 1'b0;
        exp_we      = 1'b0;
        exp_addr    = '0;
        exp_wdata   = '0;
        exp_busy    = 1'b0;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
    endtask

    task automatic drive(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_if.req = ar; a_if.wr = aw; a_if.addr = aa; a_if.wdata = ad;
        b_if.req = br; b_if.wr = bw; b_if.addr = ba; b_if.wdata = bd;
    endtask

    // One clock cycle: entered at posedge+1, checks registered outputs, drives
    // inputs, checks grants, advances the model, returns at the next posedge+1.
    task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit   ea_rv, eb_rv, ga, gb, xwr;
        ret_t r;
        ea_rv = 1'b0;
        eb_rv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.to_b) begin eb_rv = 1'b1; exp_b_rdata = r.data; end
            else        begin ea_rv = 1'b1; exp_a_rdata = r.data; end
        end
        chk("ram_we",   ram_we,   exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        if (exp_we) chk("ram_data", ram_data, exp_wdata);
        else        chk("bus_x",    $isunknown(ram_data), 0);
        chk("busy",     busy,        exp_busy);
        chk("a_rvalid", a_if.rvalid, ea_rv);
        chk("a_rdata",  a_if.rdata,  exp_a_rdata);
        chk("b_rvalid", b_if.rvalid, eb_rv);
        chk("b_rdata",  b_if.rdata,  exp_b_rdata);

        drive(ar, aw, aa, ad, br, bw, ba, bd);
        #2;
        ga = !blocked && ar && (!br || last_b);
        gb = !blocked && br && !ga;
        chk("a_gnt", a_if.gnt, ga);
        chk("b_gnt", b_if.gnt, gb);

        exp_busy = ga || gb || blocked;
        blocked  = 1'b0;
        exp_we   = 1'b0;
        if (ga || gb) begin
            last_b   = gb;
            xwr      = ga ? aw : bw;
            exp_addr = ga ? aa : ba;
            if (xwr) begin
                exp_we            = 1'b1;
                exp_wdata         = ga ? ad : bd;
                mdl_mem[exp_addr] = exp_wdata;
            end else begin
                blocked = 1'b1;
                rq.push_back('{due: cyc + 3, to_b: gb, data: mdl_mem[exp_addr]});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc = 0;
        mdl_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both write continuously from reset: A, B, A, B.
        for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 8'h11, 1, 1, 3'd1, 8'h22);
        idle(2);
        chk("mem0", ram_mem[0], 8'h11);
        chk("mem1", ram_mem[1], 8'h22);

        // A writes 0x5A to 3, then reads it back.
        step(1, 1, 3'd3, 8'h5A, 0, 0, 0, 0);
        step(1, 0, 3'd3, 8'h00, 0, 0, 0, 0);
        idle(4);

        // B reads 1 while A holds a write request through the read.
        step(1, 1, 3'd2, 8'h33, 1, 0, 3'd1, 8'h00);
        step(1, 1, 3'd2, 8'h33, 0, 0, 0, 0);
        step(1, 1, 3'd2, 8'h33, 0, 0, 0, 0);
        idle(4);

        // A fills all 8 addresses back to back, then reads 7 and 0.
        for (int i = 0; i < 8; i++) step(1, 1, AW'(i), 8'hFF, 0, 0, 0, 0);
        step(1, 0, 3'd7, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3'd0, 8'h00, 0, 0, 0, 0);
        idle(4);

        // Reset lands in the capture cycle of a B read.
        step(0, 0, 0, 0, 1, 0, 3'd5, 8'h00);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we",       ram_we,      0);
        chk("rst_addr",     ram_addr,    0);
        chk("rst_busy",     busy,        0);
        chk("rst_a_rdata",  a_if.rdata,  0);
        chk("rst_b_rvalid", b_if.rvalid, 0);
        @(posedge clk);
        #1;
        chk("rst_b_rvalid2", b_if.rvalid, 0);
        chk("rst_b_rdata",   b_if.rdata,  0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mdl_reset();
        step(1, 1, 3'd4, 8'hA4, 1, 1, 3'd6, 8'hB6);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Random traffic from both requesters.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
        end
        idle(5);
        for (int i = 0; i < 8; i++) chk("mem_final", ram_mem[i], mdl_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM with its shared bidirectional data bus.
- Owns the RAM-side we/address/data pins and converts per-requester valid/ready transactions into correctly timed RAM write and read cycles.
- Manages bus turnaround and returns read data to the requester that issued the read.

Parameters:
- DATA_WIDTH, 8, width of the RAM data bus and the requester data.
- ADDR_WIDTH, 3, RAM address width (depth 2**ADDR_WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A transaction valid.
- a_wr  in  1  A: 1 = write, 0 = read; qualified by a_req.
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A accepted (combinational); transfer occurs on an edge with a_req&a_gnt.
- a_rdata  out  DATA_WIDTH  A read data, registered.
- a_rvalid  out  1  one-cycle pulse, a_rdata valid.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as A for requester B.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  ADDR_WIDTH  RAM address, registered.
- ram_data  inout  DATA_WIDTH  shared RAM data bus; driven only while ram_we=1, otherwise high-Z.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, ram_we=0, ram_addr=0, ram_data=Z, a/b_rdata=0, a/b_rvalid=0, busy=0, round-robin pointer last=B (A wins the first conflict).
- FSM states:
  - IDLE.
  - WRITE: ram_we=1, ram_addr and ram_data = latched request.
  - READ: ram_we=0, ram_addr = latched address; RAM latches its output at the end of this cycle.
  - RCAP: ram_we=0; the RAM drives ram_data; the arbiter captures it at the end of the cycle.
- free = state in {IDLE, WRITE, RCAP}. Grants are possible only when free; both gnt=0 in READ.
- Arbitration, when free:
  - Only one requester asserting req: it is granted.
  - Both asserting: the requester not granted last is granted.
  - Pointer updates on every accepted transfer.
- On an accepted transfer, addr/wdata/wr and the owner ID are latched. Next state is WRITE if wr, else READ. With no transfer, a free state goes to IDLE.
- READ always goes to RCAP.
- Write timing: gnt in cycle C0; WRITE in C1 with data driven; the RAM writes on the edge ending C1. A write is occupied for 1 cycle, so back-to-back writes run at 1 per cycle.
- Read timing: gnt in C0; READ in C1; RCAP in C2; owner's rdata updated and rvalid=1 in C3 only. Non-owner rvalid stays 0 and its rdata holds.
- A read occupies the bus for 2 cycles. A new request may be granted in RCAP; a following WRITE may drive the bus in C3 because capture completes at the end of C2.
- No bus contention:
  - ram_data drive enable and ram_we come from the same registered state decode.
  - The RAM drives only when ram_we=0; the arbiter drives only when ram_we=1.
- Read-after-write, same address: the write in C1 and the read accepted at the end of C1 return the new data.
- The arbiter never reorders transactions. Each requester has at most one read returning at a time, because reads are serialized.
- Requester inputs need be stable only in the cycle they are accepted. req may stay high for back-to-back transactions.
- busy = (state != IDLE).
- Reset mid-operation: all outputs go immediately to reset values.
  - A pending read produces no rvalid.
  - A write whose WRITE cycle is cut short by reset is not guaranteed to reach memory.

Test Plan:
- A writes 0x5A to addr 3 (a_req=1, a_wr=1) -> a_gnt=1 same cycle; next cycle ram_we=1, ram_addr=3, ram_data=0x5A; busy=1.
- After that write, A reads addr 3 -> ram_we=0 for 2 cycles; a_rvalid pulses exactly 1 cycle, 3 cycles after the grant cycle, with a_rdata=0x5A; b_rvalid stays 0.
- A and B request continuously from reset (writes of 0x11 and 0x22 to addr 0 and 1) -> grants alternate A, B, A, B; RAM holds addr0=0x11, addr1=0x22.
- B reads addr 1 while A holds a write request -> no gnt during READ; A granted in RCAP; A's WRITE cycle follows with no cycle where both sides drive ram_data (check no X on bus).
- Back-to-back writes of 0xFF to all 8 addresses by A alone -> 8 consecutive WRITE cycles; read-back of address 7 then 0 returns 0xFF; the address wraps to 0 with no error.
- Assert rst_n=0 during RCAP of a B read -> b_rvalid never pulses; all outputs at reset values asynchronously; first post-reset conflict is granted to A.
